// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: word width, default debounce length, register
// offsets used by the GPIO block and its input-conditioning stage, and the
// debounce state type.
package gpio_pkg;

    localparam int GPIO_WIDTH        = 32;
    localparam int GPIO_DEBOUNCE_DEF = 16;

    // Register offsets shared with the GPIO block (0..8)
    localparam logic [3:0] GPIO_REG_DATA_IN  = 4'd0;
    localparam logic [3:0] GPIO_REG_DATA_OUT = 4'd1;
    localparam logic [3:0] GPIO_REG_DIR      = 4'd2;
    localparam logic [3:0] GPIO_REG_INT_EN   = 4'd3;
    localparam logic [3:0] GPIO_REG_INT_STAT = 4'd4;
    localparam logic [3:0] GPIO_REG_INT_CLR  = 4'd5;
    localparam logic [3:0] GPIO_REG_EDGE_SEL = 4'd6;
    localparam logic [3:0] GPIO_REG_POLARITY = 4'd7;
    localparam logic [3:0] GPIO_REG_LOAD     = 4'd8;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } sync_state_t;

endpackage

// File: rtl/gpio_sync_2ff.sv
// Two-stage synchroniser for an asynchronous pin word. q is d delayed by two
// clk edges; async active-low reset clears both stages.
module gpio_sync_2ff #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to resolve
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpio_input_sync.sv
// GPIO input conditioning: synchronise raw pins, debounce the whole word and
// hand each accepted, changed value to the GPIO with a one-cycle load pulse
// plus the mask of bits that changed.
//
// Build option GPIO_SYNC_DEBOUNCE_EN:
//   defined   - word must hold unchanged for DEBOUNCE samples before acceptance
//   undefined - any synchronised change is accepted on the next edge, busy=0
//
// state  | meaning
// IDLE   | synchronised pins equal data_out, nothing pending
// SETTLE | a different value is being timed; any bit change restarts the window
module gpio_input_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH    = GPIO_WIDTH,
    parameter int DEBOUNCE = GPIO_DEBOUNCE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] data_out,
    output logic             load_pulse,
    output logic [WIDTH-1:0] change_mask,
    output logic             busy
);

    logic [WIDTH-1:0] s2;

    gpio_sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_in),
        .q   (s2)
    );

`ifdef GPIO_SYNC_DEBOUNCE_EN

    localparam int CNT_W = $clog2(DEBOUNCE) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    sync_state_t      state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] candidate;

    // Debounce FSM: counter only runs in SETTLE and is cleared on every exit,
    // so it never passes DEBOUNCE-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            candidate   <= '0;
            data_out    <= '0;
            change_mask <= '0;
            load_pulse  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            load_pulse  <= 1'b0;
            change_mask <= '0;
            unique case (state)
                IDLE: begin
                    if (s2 != data_out) begin
                        candidate <= s2;
                        count     <= CNT_ONE;
                        state     <= SETTLE;
                        busy      <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (s2 != candidate) begin
                        candidate <= s2;
                        count     <= CNT_ONE;
                    end else if (s2 == data_out) begin
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        data_out    <= candidate;
                        change_mask <= candidate ^ data_out;
                        load_pulse  <= 1'b1;
                        count       <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`else

    // DEBOUNCE has no effect in this build
    logic unused_debounce;
    assign unused_debounce = ^(32'(DEBOUNCE));

    // Pass-through: every synchronised change is loaded on the following edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out    <= '0;
            change_mask <= '0;
            load_pulse  <= 1'b0;
        end else begin
            load_pulse  <= 1'b0;
            change_mask <= '0;
            if (s2 != data_out) begin
                data_out    <= s2;
                change_mask <= s2 ^ data_out;
                load_pulse  <= 1'b1;
            end
        end
    end

    assign busy = 1'b0;

`endif

endmodule

// File: tb/tb_gpio_input_sync.sv
// Self-checking bench for gpio_input_sync: directed scenarios with literal
// expectations plus randomized pin activity checked every cycle against a
// sample-history model ("a value is accepted once it has been seen on the
// synchronised pins for N consecutive samples and differs from data_out").
module tb_gpio_input_sync;
    import gpio_pkg::*;

    localparam int W  = 32;
    localparam int DB = 16;
`ifdef GPIO_SYNC_DEBOUNCE_EN
    localparam bit DBEN = 1'b1;
    localparam int MDB  = DB;
`else
    localparam bit DBEN = 1'b0;
    localparam int MDB  = 1;
`endif
    localparam int LAT            = MDB + 2;
    localparam int EXP_T3_PULSES  = DBEN ? 0 : 2;
    localparam int EXP_T4_PULSES  = DBEN ? 1 : 3;
    localparam logic [W-1:0] EXP_T4_MASK = DBEN ? 32'h0000_005A : 32'h0000_0001;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] pin_in = '0;
    logic [W-1:0] data_out;
    logic         load_pulse;
    logic [W-1:0] change_mask;
    logic         busy;

    gpio_input_sync #(.WIDTH(W), .DEBOUNCE(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .pin_in      (pin_in),
        .data_out    (data_out),
        .load_pulse  (load_pulse),
        .change_mask (change_mask),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int step_cyc = 0;
    int pulse_cnt = 0;
    bit busy_seen = 1'b0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] q_pin[$];
    logic [W-1:0] m_dout = '0, m_mask = '0, m_prev = '0, m_v;
    logic         m_pulse = 1'b0, m_busy = 1'b0;
    int           m_run = 0;
    bit           m_acc, m_diff_prev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_pin.delete();
            m_dout = '0; m_mask = '0; m_prev = '0;
            m_pulse = 1'b0; m_busy = 1'b0; m_run = 0;
        end else begin
            // synchronised value seen at this edge = pin sampled two edges ago
            m_v = (q_pin.size() >= 2) ? q_pin[q_pin.size()-2] : '0;
            m_diff_prev = (m_v != m_prev);
            m_run = m_diff_prev ? 1 : m_run + 1;
            m_prev = m_v;
            m_acc = (m_v != m_dout) && (m_run >= MDB);
            m_busy = DBEN && !m_acc && ((m_v != m_dout) || (m_busy && m_diff_prev));
            m_pulse = m_acc;
            m_mask = m_acc ? (m_v ^ m_dout) : '0;
            if (m_acc) m_dout = m_v;
            q_pin.push_back(pin_in);
            if (q_pin.size() > 2) void'(q_pin.pop_front());
        end
    end

    always @(posedge clk) cyc++;

    // Every-cycle comparison against the model, plus pulse/busy bookkeeping
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out", data_out, m_dout);
            chk("load_pulse", W'(load_pulse), W'(m_pulse));
            chk("change_mask", change_mask, m_mask);
            chk("busy", W'(busy), W'(m_busy));
        end
        if (load_pulse) pulse_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [W-1:0] val);
        @(posedge clk); #2;
        pin_in = val;
        step_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Watch n cycles; report pulse count and latency/data/mask of the last pulse
    task automatic observe(input int n, output int cnt, output int lat,
                           output logic [W-1:0] d, output logic [W-1:0] m);
        cnt = 0; lat = -1; d = '0; m = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (load_pulse) begin
                cnt++;
                lat = cyc - step_cyc;
                d = data_out;
                m = change_mask;
            end
        end
    endtask

    int cnt, lat, p0;
    logic [W-1:0] od, om, cur, nv;

    initial begin
        // T1: reset then quiet pins
        rst = 1'b0; pin_in = '0;
        idle(3);
        #2 rst = 1'b1;
        @(negedge clk); chk_en = 1'b1;
        p0 = pulse_cnt; busy_seen = 1'b0;
        idle(50);
        chk("t1_pulses", W'(pulse_cnt - p0), '0);
        chk("t1_busy_seen", W'(busy_seen), '0);
        chk("t1_data", data_out, '0);

        // T2: 0 -> 0xA5
        p0 = pulse_cnt;
        step(32'h0000_00A5);
        observe(45, cnt, lat, od, om);
        chk("t2_pulses", W'(cnt), 32'd1);
        chk("t2_latency", W'(lat), W'(LAT));
        chk("t2_data", od, 32'h0000_00A5);
        chk("t2_mask", om, 32'h0000_00A5);

        // T3: 10-cycle glitch on bit 31
        p0 = pulse_cnt; busy_seen = 1'b0;
        step(32'h8000_00A5);
        idle(9);
        step(32'h0000_00A5);
        idle(40);
        #1;
        chk("t3_pulses", W'(pulse_cnt - p0), W'(EXP_T3_PULSES));
        chk("t3_data", data_out, 32'h0000_00A5);
        chk("t3_busy_seen", W'(busy_seen), W'(DBEN));
        chk("t3_busy_end", W'(busy), '0);

        // T4: 0xA5 -> 0xFF with a bit-0 toggle at cycle 8 of the window
        p0 = pulse_cnt;
        step(32'h0000_00FF);
        idle(7);
        step(32'h0000_00FE);
        step(32'h0000_00FF);
        observe(45, cnt, lat, od, om);
        chk("t4_pulses", W'(pulse_cnt - p0), W'(EXP_T4_PULSES));
        chk("t4_latency", W'(lat), W'(LAT));
        chk("t4_data", od, 32'h0000_00FF);
        chk("t4_mask", om, EXP_T4_MASK);

        // T5: reset asserted at cycle 10 of a window
        step(32'hFFFF_FFFF);
        idle(9);
        @(posedge clk); #2 rst = 1'b0;
        idle(2);
        @(negedge clk);
        chk("t5_rst_data", data_out, '0);
        chk("t5_rst_pulse", W'(load_pulse), '0);
        chk("t5_rst_mask", change_mask, '0);
        chk("t5_rst_busy", W'(busy), '0);
        @(posedge clk); #2 rst = 1'b1; step_cyc = cyc;
        observe(45, cnt, lat, od, om);
        chk("t5_pulses", W'(cnt), 32'd1);
        chk("t5_latency", W'(lat), W'(LAT));
        chk("t5_data", od, 32'hFFFF_FFFF);
        chk("t5_mask", om, 32'hFFFF_FFFF);

        // Randomized pin activity, model checked every cycle
        cur = pin_in;
        for (int seg = 0; seg < 160; seg++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                @(posedge clk); #2 rst = 1'b0;
                idle($urandom_range(1, 3));
                @(posedge clk); #2 rst = 1'b1;
            end else begin
                if (r < 5)       nv = $urandom;
                else if (r < 12) nv = cur ^ (32'h1 << $urandom_range(0, 31));
                else if (r < 15) nv = cur ^ ($urandom & 32'h0000_000F);
                else             nv = cur;
                step(nv);
                cur = nv;
                idle($urandom_range(0, 24));
            end
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net: never hang
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
